uart_receiver_stage3: RTL and testbench
=======================================

UART_RECEIVER_STAGE3 -- requirements
Module: uart_receiver_stage3

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per bit (100 MHz, 115200 baud).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port RX, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-005 The block SHALL have port bufClr, input, 1 bit: synchronous clear of RXBUF, level-sensitive.
REQ-006 The block SHALL have port RXBUF[3:0], output, 8 bits each: received-byte history; [0] is newest.
REQ-007 The block SHALL have port outLight, output, 8 bits: mirrors RXBUF[0], for the LEDs.
REQ-008 The block SHALL have port rxValid, output, 1 bit: one-cycle pulse per accepted byte.
REQ-009 The block SHALL have port frameErr, output, 1 bit: one-cycle pulse per rejected frame.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 RX SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic SHALL use the synchronized value rxS.
REQ-012 The frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAITHI.
REQ-014 IDLE: rxS==0 SHALL move the FSM to START with the bit-timer cleared.
REQ-015 START: rxS SHALL be sampled when the timer reaches CLKS_PER_BIT/2-1 (integer division); 0 goes to DATA, 1 returns to IDLE (glitch rejected, no pulse).
REQ-016 DATA: rxS SHALL be sampled every CLKS_PER_BIT cycles after the previous sample into a shift register, LSB first; after the 8th sample the FSM goes to STOP.
REQ-017 STOP: rxS SHALL be sampled CLKS_PER_BIT cycles after the 8th data sample.
REQ-018 STOP sample 1 SHALL push the byte in the next cycle: RXBUF[3]<=[2], [2]<=[1], [1]<=[0], [0]<=byte; rxValid high that cycle; then IDLE.
REQ-019 STOP sample 0 SHALL leave RXBUF unchanged, pulse frameErr in the next cycle, and go to WAITHI.
REQ-020 WAITHI SHALL return to IDLE on the first cycle with rxS==1; no new start SHALL be detected until then.
REQ-021 The bit-timer SHALL be wide enough for CLKS_PER_BIT-1, reset to 0 on every sample and every state entry, and never wrap.
REQ-022 When the buffer holds four bytes, a push SHALL discard the oldest byte (RXBUF[3]); no overflow flag.
REQ-023 bufClr SHALL zero all four RXBUF entries next cycle without disturbing the FSM.
REQ-024 bufClr and a push in the same cycle SHALL give RXBUF[0]=new byte and [3:1]=0.
REQ-025 outLight SHALL equal RXBUF[0] combinationally at all times.
REQ-026 rxValid and frameErr SHALL never be high together, and each SHALL be high for exactly one cycle per frame.

Reset
REQ-027 Asserting reset SHALL immediately set the FSM to IDLE, the timer, bit counter and shift register to 0, RXBUF[*] and outLight to 0x00, rxValid, frameErr and busy to 0, and the synchronizer to 1.
REQ-028 Reset during a frame SHALL abandon the frame with no pulse; after release the remaining bits SHALL be treated as a new start only on an observed 0 in IDLE.

Verification
REQ-029 Send 0xA5 at CLKS_PER_BIT -> one rxValid pulse, RXBUF[0]=outLight=0xA5, frameErr never high, busy low after the stop sample.
REQ-030 Send 0x11,0x22,0x33,0x44,0x55 back-to-back -> five rxValid pulses, RXBUF[0..3]=0x55,0x44,0x33,0x22 (0x11 discarded).
REQ-031 Drive RX low for 200 cycles, then high -> no rxValid or frameErr, FSM back in IDLE, RXBUF unchanged.
REQ-032 Send 0x3C with stop bit 0, hold low 2000 cycles, then send 0x7E -> one frameErr pulse, 0x3C not stored, then rxValid with RXBUF[0]=0x7E.
REQ-033 Assert reset during data bit 4 of 0x96 -> all outputs 0 immediately; a following 0x5A is received correctly.
REQ-034 With RXBUF=0x01,0x02,0x03,0x04, assert bufClr in the rxValid cycle of 0xEE -> RXBUF[0]=0xEE, [3:1]=0x00.

Source files
------------

// File: rtl/uart_receiver_stage3.sv
// uart_receiver_stage3: 8N1 UART receiver with a 2-flop input synchronizer,
// mid-bit sampling, a 4-entry received-byte history and one-cycle pulses for
// each accepted byte (rxValid) and each rejected frame (frameErr).
module uart_receiver_stage3 #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RX,
    input  logic            bufClr,
    output logic [3:0][7:0] RXBUF,
    output logic [7:0]      outLight,
    output logic            rxValid,
    output logic            frameErr,
    output logic            busy
);

    // Bit timer only ever has to hold CLKS_PER_BIT-1.
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_d, ferr_d;
    logic            valid_q, ferr_q;
    logic            rx_meta_q, rxS_q;
    logic [3:0][7:0] buf_q;

    // Two-flop synchronizer; idle-high line so both flops reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxS_q     <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rxS_q     <= rx_meta_q;
        end
    end

    // FSM, bit timer, bit counter, shift register and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            valid_q  <= push_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state logic: sample mid start bit, then every full bit period.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        push_d   = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d  = '0;
                bitcnt_d = '0;
                if (!rxS_q) state_d = START;
            end
            START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    // A high line at mid start bit was only a glitch.
                    state_d = rxS_q ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d  = '0;
                    shift_d  = {rxS_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (rxS_q) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAITHI;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAITHI: begin
                // Hold off start detection until the line returns high.
                timer_d = '0;
                if (rxS_q) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // History buffer: push happens in the rxValid cycle so a coincident
    // bufClr keeps the new byte and clears only the older entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
        end else if (valid_q && bufClr) begin
            buf_q <= {24'h0, shift_q};
        end else if (bufClr) begin
            buf_q <= '0;
        end else if (valid_q) begin
            buf_q <= {buf_q[2:0], shift_q};
        end
    end

    assign RXBUF    = buf_q;
    assign outLight = buf_q[0];
    assign rxValid  = valid_q;
    assign frameErr = ferr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver_stage3.sv
// Bench for uart_receiver_stage3: serial frames at a short bit period,
// expected history kept as a newest-first byte queue.
module tb_uart_receiver_stage3;
    localparam int CPB = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            RX;
    logic            bufClr;
    logic [3:0][7:0] RXBUF;
    logic [7:0]      outLight;
    logic            rxValid, frameErr, busy;

    int checks = 0;
    int errors = 0;
    int nvalid = 0, nferr = 0, overlap = 0;
    byte unsigned hist[$];

    uart_receiver_stage3 #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .RX(RX), .bufClr(bufClr),
        .RXBUF(RXBUF), .outLight(outLight), .rxValid(rxValid),
        .frameErr(frameErr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rxValid) nvalid++;
        if (frameErr) nferr++;
        if (rxValid && frameErr) overlap++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_buf();
        logic [31:0] v = '0;
        for (int i = 0; i < hist.size() && i < 4; i++) v[i*8 +: 8] = hist[i];
        return v;
    endfunction

    task automatic hist_push(input logic [7:0] d);
        hist.push_front(d);
        if (hist.size() > 4) void'(hist.pop_back());
    endtask

    // One 8N1 frame, CPB cycles per bit; optional one-cycle bufClr at clr_at.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input int clr_at);
        logic [9:0] bits;
        int n;
        bits = {stopb, d, 1'b0};
        n = 0;
        for (int b = 0; b < 10; b++) begin
            RX = bits[b];
            for (int c = 0; c < CPB; c++) begin
                if (clr_at >= 0) bufClr = (n == clr_at);
                tick();
                n++;
            end
        end
        if (clr_at >= 0) bufClr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; RX = 1'b1; bufClr = 1'b0;
        repeat (3) tick();
        checks++; if (RXBUF !== 32'h0) begin errors++; $display("FAIL reset_rxbuf got %h want 0", RXBUF); end
        checks++; if (outLight !== 8'h0) begin errors++; $display("FAIL reset_outlight got %h want 0", outLight); end
        checks++; if ({rxValid, frameErr, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {rxValid, frameErr, busy}); end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_single();
        int v0, f0;
        v0 = nvalid; f0 = nferr;
        send_frame(8'hA5, 1'b1, -1);
        hist_push(8'hA5);
        repeat (2) tick();
        checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL single_valid got %0d want 1", nvalid - v0); end
        checks++; if (nferr - f0 !== 0) begin errors++; $display("FAIL single_ferr got %0d want 0", nferr - f0); end
        checks++; if (RXBUF !== exp_buf()) begin errors++; $display("FAIL single_rxbuf got %h want %h", RXBUF, exp_buf()); end
        checks++; if (outLight !== 8'hA5) begin errors++; $display("FAIL single_outlight got %h want a5", outLight); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic [7:0] seq [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        v0 = nvalid;
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b1, -1);
            hist_push(seq[i]);
        end
        repeat (2) tick();
        checks++; if (nvalid - v0 !== 5) begin errors++; $display("FAIL b2b_valid got %0d want 5", nvalid - v0); end
        checks++; if (RXBUF !== 32'h22334455) begin errors++; $display("FAIL b2b_rxbuf got %h want 22334455", RXBUF); end
        checks++; if (RXBUF !== exp_buf()) begin errors++; $display("FAIL b2b_model got %h want %h", RXBUF, exp_buf()); end
    endtask

    task automatic test_glitch();
        int v0, f0, len;
        v0 = nvalid; f0 = nferr;
        for (int i = 0; i < 3; i++) begin
            len = $urandom_range(1, CPB / 2 - 4);
            RX = 1'b0;
            repeat (len) tick();
            RX = 1'b1;
            repeat (2 * CPB) tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy len %0d got %b want 0", len, busy); end
        end
        checks++; if ((nvalid - v0) + (nferr - f0) !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", (nvalid - v0) + (nferr - f0)); end
        checks++; if (RXBUF !== exp_buf()) begin errors++; $display("FAIL glitch_rxbuf got %h want %h", RXBUF, exp_buf()); end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = nvalid; f0 = nferr;
        send_frame(8'h3C, 1'b0, -1);
        RX = 1'b0;
        repeat (4 * CPB) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_waithi_busy got %b want 1", busy); end
        checks++; if (nferr - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", nferr - f0); end
        checks++; if (nvalid - v0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", nvalid - v0); end
        checks++; if (RXBUF !== exp_buf()) begin errors++; $display("FAIL ferr_rxbuf got %h want %h", RXBUF, exp_buf()); end
        RX = 1'b1;
        repeat (CPB) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle_busy got %b want 0", busy); end
        send_frame(8'h7E, 1'b1, -1);
        hist_push(8'h7E);
        repeat (2) tick();
        checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL ferr_next_valid got %0d want 1", nvalid - v0); end
        checks++; if (nferr - f0 !== 1) begin errors++; $display("FAIL ferr_total got %0d want 1", nferr - f0); end
        checks++; if (RXBUF !== exp_buf()) begin errors++; $display("FAIL ferr_next_rxbuf got %h want %h", RXBUF, exp_buf()); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        int v0, f0;
        bits = {1'b1, 8'h96, 1'b0};
        for (int b = 0; b < 5; b++) begin
            RX = bits[b];
            repeat (CPB) tick();
        end
        RX = bits[5];
        repeat (CPB / 2) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        v0 = nvalid; f0 = nferr;
        #2 reset = 1'b1;
        #1;
        hist.delete();
        checks++; if (RXBUF !== 32'h0) begin errors++; $display("FAIL midrst_rxbuf got %h want 0", RXBUF); end
        checks++; if (outLight !== 8'h0) begin errors++; $display("FAIL midrst_outlight got %h want 0", outLight); end
        checks++; if ({rxValid, frameErr, busy} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b want 000", {rxValid, frameErr, busy}); end
        RX = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (CPB) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b want 0", busy); end
        send_frame(8'h5A, 1'b1, -1);
        hist_push(8'h5A);
        repeat (2) tick();
        checks++; if (nvalid - v0 !== 1 || nferr - f0 !== 0) begin errors++; $display("FAIL midrst_pulses got v%0d f%0d want v1 f0", nvalid - v0, nferr - f0); end
        checks++; if (RXBUF !== exp_buf()) begin errors++; $display("FAIL midrst_rxbuf_after got %h want %h", RXBUF, exp_buf()); end
    endtask

    task automatic test_bufclr();
        logic found;
        logic [7:0] pre [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
        foreach (pre[i]) begin
            send_frame(pre[i], 1'b1, -1);
            hist_push(pre[i]);
        end
        tick();
        checks++; if (RXBUF !== 32'h04030201) begin errors++; $display("FAIL clr_prefill got %h want 04030201", RXBUF); end
        found = 1'b0;
        fork
            send_frame(8'hEE, 1'b1, -1);
            begin
                for (int k = 0; k < 400 && !found; k++) begin
                    tick();
                    if (rxValid) begin
                        found = 1'b1;
                        bufClr = 1'b1;
                        tick();
                        bufClr = 1'b0;
                    end
                end
            end
        join
        hist.delete();
        hist_push(8'hEE);
        tick();
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL clr_wait got no rxValid want pulse"); end
        checks++; if (RXBUF !== 32'h000000EE) begin errors++; $display("FAIL clr_with_push got %h want 000000ee", RXBUF); end
        // Clear in the middle of a frame must not disturb reception.
        send_frame(8'hC3, 1'b1, 60);
        hist.delete();
        hist_push(8'hC3);
        repeat (2) tick();
        checks++; if (RXBUF !== exp_buf()) begin errors++; $display("FAIL clr_midframe got %h want %h", RXBUF, exp_buf()); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int v0, gap, mid;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            mid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 140)) : -1;
            v0 = nvalid;
            send_frame(d, 1'b1, mid);
            if (mid >= 0) hist.delete();
            hist_push(d);
            gap = $urandom_range(2, CPB);
            repeat (gap) tick();
            checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL rand_valid[%0d] got %0d want 1", i, nvalid - v0); end
            checks++; if (RXBUF !== exp_buf() || outLight !== hist[0]) begin errors++; $display("FAIL rand_rxbuf[%0d] got %h/%h want %h", i, RXBUF, outLight, exp_buf()); end
            if ($urandom_range(0, 4) == 0) begin
                bufClr = 1'b1;
                tick();
                bufClr = 1'b0;
                hist.delete();
                checks++; if (RXBUF !== 32'h0) begin errors++; $display("FAIL rand_idleclr[%0d] got %h want 0", i, RXBUF); end
            end
        end
    endtask

    task automatic test_exclusive();
        checks++; if (overlap !== 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_bufclr();
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
